lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
- Parametrised load/store unit between the CPU datapath (LDR/STR/LDRB/STRB) and a variable-latency data memory.
- Successor to the fixed single-cycle ReadData/WriteData/MemWrite path.
- Adds a valid/ready request handshake, byte/halfword/word lanes, an alignment check and a memory-ack timeout.
- The CPU stalls on `busy` while an access is in flight.

Parameters:
- DATA_W, 32, memory/bus data width; must be 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack before an error response; must be at least 1.
- LANES, DATA_W/8, derived; byte lanes per word. Not overridable.
- OFS_W, log2(LANES), derived; address offset bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents an access.
- req_ready  out  1  bridge accepts the access this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64).
- req_addr  in  ADDR_W  byte address (ALUResult).
- req_wdata  in  DATA_W  store data (WriteData), right-aligned.
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_rdata  out  DATA_W  load data, zero-extended, right-aligned.
- resp_err  out  1  valid with resp_valid: misaligned access, illegal size or timeout.
- busy  out  1  access in flight (CPU stall).
- mem_req  out  1  memory request strobe, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (low OFS_W bits zero).
- mem_be  out  LANES  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  memory completes the access; read data is valid in the same cycle.
- mem_rdata  in  DATA_W  full memory word.

Behaviour:
- Reset (rst = 0, async): FSM goes to IDLE.
  - All outputs 0, except req_ready = 1.
  - Timeout counter cleared; latched request cleared.
- FSM states and transitions:
  - IDLE: req_ready = 1.
    - On req_valid with a legal, aligned request: latch addr/size/write/wdata, go to ACCESS.
    - On req_valid with a misaligned or illegal request: go to RESP with err = 1. No memory access is issued.
  - ACCESS: mem_req = 1; busy = 1; req_ready = 0; mem_* held stable.
    - Counter increments every cycle without ack.
    - On mem_ack: capture the lane-extracted rdata (loads only), go to RESP, err = 0.
    - If the counter reaches TIMEOUT without ack: drop mem_req, go to RESP with err = 1, rdata = 0.
  - RESP: resp_valid = 1 for exactly one cycle; busy = 1; req_ready = 0. Always returns to IDLE; a new request is accepted one cycle later.
- Latency:
  - Zero-wait memory (ack in the first ACCESS cycle): 2 cycles from acceptance to resp_valid.
  - Misaligned/illegal request: resp_valid 1 cycle after acceptance.
- Alignment: access is legal when addr[size-1:0] == 0. Bytes are always aligned.
- Lanes (little-endian), with ofs = addr[OFS_W-1:0]:
  - mem_be = ((1 << (1 << size)) - 1) << ofs.
  - mem_wdata = req_wdata low (8 << size) bits replicated across the word.
  - Load: resp_rdata = (mem_rdata >> 8*ofs), masked to the access size, upper bits zero.
  - Word load on DATA_W = 32 returns mem_rdata unchanged.
- Loads drive mem_we = 0 and mem_be per the size; the memory ignores mem_be for reads.
- Boundaries:
  - mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
  - mem_ack outside ACCESS is ignored.
  - req_valid during ACCESS/RESP is not accepted (req_ready = 0); the CPU holds the request.
  - Reset mid-ACCESS aborts immediately: mem_req = 0 asynchronously, no resp_valid.
  - resp_rdata holds its last value until the next response, except after a timeout, which zeroes it.

Decomposition:
- Package lsu_pkg:
  - enum lsu_state_t {IDLE, ACCESS, RESP}.
  - enum lsu_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD}.
  - Function lane_mask(size, ofs).
- Sub-module lsu_lane_align (combinational): generates mem_be, replicates write data and extracts read data. Instantiated once.
- The FSM and timeout counter stay in lsu_mem_bridge.

Test Plan:
- LDR, zero wait (addr 0x1000, size 2, mem_rdata 0x00000004, ack in the first ACCESS cycle) -> mem_addr 0x1000, mem_be 4'b1111, resp_valid 2 cycles after acceptance, resp_rdata 0x4, err 0.
- STRB, 3 wait cycles (addr 0x1003, wdata 0xA5) -> mem_we 1, mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_req held 4 cycles, busy for 5 cycles, resp_valid once.
- LDRH from 0x1002 with mem_rdata 0xBEEF1234 -> resp_rdata 0x0000BEEF. LDRH from 0x1001 -> resp_err 1 one cycle after acceptance, mem_req never asserted.
- No ack, TIMEOUT = 16 -> mem_req high exactly 16 cycles then drops; resp_valid with resp_err 1 and resp_rdata 0.
- rst pulled low during ACCESS -> mem_req and busy drop without waiting for clk, no resp_valid; req_ready = 1 after release, and the next LDR completes normally.
- DATA_W = 64, size 3 at 0x2008 -> mem_be 8'hFF. Size 3 with DATA_W = 32 -> resp_err 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_DWORD
  } lsu_size_t;

  // Widest bus supported (64-bit data) has eight byte lanes.
  localparam int MAX_LANES = 8;

  // Byte-enable pattern for an access of the given size starting at lane ofs.
  function automatic logic [MAX_LANES-1:0] lane_mask(input lsu_size_t size,
                                                     input logic [2:0] ofs);
    logic [MAX_LANES-1:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << ofs;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, store-data replication, load-data extraction.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFS_W  = $clog2(LANES)
) (
  input  lsu_size_t         size,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata
);

  int nbytes;
  logic [DATA_W-1:0] shifted;

  assign nbytes  = 1 << size;
  assign be      = LANES'(lane_mask(size, 3'(ofs)));
  assign shifted = mem_rdata >> {ofs, 3'b000};

  // Replicate the low access-size bytes of the store data across every lane.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    wdata_rep = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata_rep[8*i +: 8] = wdata[8*(i & (nbytes - 1)) +: 8];
    end
  end

  // Right-align the addressed bytes and zero everything above the access size.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < nbytes) rdata[8*i +: 8] = shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the CPU datapath and a variable-latency data memory.
// One access in flight at a time; the CPU stalls on busy until resp_valid.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 16,
  localparam int LANES   = DATA_W / 8,
  localparam int OFS_W   = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_t         size_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  lsu_size_t         req_sz;
  logic [OFS_W-1:0]  low_mask;
  logic              size_ok;
  logic              req_ok;
  logic              timeout_hit;
  logic [LANES-1:0]  lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  // A request is legal when the size fits the bus and the address is size-aligned.
  assign req_sz      = lsu_size_t'(req_size);
  assign low_mask    = OFS_W'((1 << req_size) - 1);
  assign size_ok     = (req_sz != SZ_DWORD) || (DATA_W == 64);
  assign req_ok      = size_ok && ((req_addr[OFS_W-1:0] & low_mask) == '0);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (size_q),
    .ofs       (addr_q[OFS_W-1:0]),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata     (lane_rdata)
  );

  // State register; reset aborts any access in flight without a response.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values present before the clock edge.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy       = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_ok ? ACCESS : RESP;
      end
      ACCESS: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // An ack in the final counted cycle still completes the access.
        if (mem_ack || timeout_hit) state_d = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req_valid) begin
            err_q <= !req_ok;
            if (req_ok) begin
              addr_q  <= req_addr;
              size_q  <= req_sz;
              write_q <= req_write;
              wdata_q <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            err_q <= 1'b0;
            if (!write_q) rdata_q <= lane_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side signals are only driven while the access is outstanding.
  assign mem_we     = mem_req & write_q;
  assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
  assign mem_be     = mem_req ? lane_be : '0;
  assign mem_wdata  = mem_req ? lane_wdata : '0;
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Bench for lsu_mem_bridge: a 32-bit and a 64-bit instance share stimulus;
// each access is predicted from the lane/alignment/latency rules with plain
// arithmetic and compared cycle by cycle against the selected instance.
module tb_lsu_mem_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v32, v64;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        rdy32, rv32, err32, busy32, mreq32, mwe32;
  logic [31:0] rd32, maddr32, mwd32;
  logic [3:0]  be32;
  logic        rdy64, rv64, err64, busy64, mreq64, mwe64;
  logic [63:0] rd64, mwd64;
  logic [31:0] maddr64;
  logic [7:0]  be64;

  lsu_mem_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(v32), .req_ready(rdy32), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv32), .resp_rdata(rd32), .resp_err(err32), .busy(busy32),
    .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(be32),
    .mem_wdata(mwd32), .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0])
  );

  lsu_mem_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(5)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(v64), .req_ready(rdy64), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv64), .resp_rdata(rd64), .resp_err(err64), .busy(busy64),
    .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(be64),
    .mem_wdata(mwd64), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Outputs of whichever instance is under test.
  bit          sel64;
  logic        o_ready, o_rv, o_err, o_busy, o_mreq, o_mwe;
  logic [63:0] o_rdata, o_maddr, o_be, o_mwd;
  assign o_ready = sel64 ? rdy64  : rdy32;
  assign o_rv    = sel64 ? rv64   : rv32;
  assign o_err   = sel64 ? err64  : err32;
  assign o_busy  = sel64 ? busy64 : busy32;
  assign o_mreq  = sel64 ? mreq64 : mreq32;
  assign o_mwe   = sel64 ? mwe64  : mwe32;
  assign o_rdata = sel64 ? rd64   : 64'(rd32);
  assign o_maddr = sel64 ? 64'(maddr64) : 64'(maddr32);
  assign o_be    = sel64 ? 64'(be64) : 64'(be32);
  assign o_mwd   = sel64 ? mwd64  : 64'(mwd32);

  int total = 0;
  int bad   = 0;
  logic [63:0] last_rd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dw=%0d got=0x%0h exp=0x%0h t=%0t", tag, sel64 ? 64 : 32, got, exp, $time);
    end
  endtask

  // One CPU access with memory ack on the (wait_n+1)-th request cycle.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata, input int wait_n);
    int lanes, nbytes, tmo, ofs, n, req_cnt, busy_cnt, resp_at, e_resp_at, e_req_cnt, idx;
    logic legal, e_err, got_err, stable, s_we;
    logic [63:0] word_mask, e_be, e_wd, e_rd, e_addr, rd_word, got_rd, s_addr, s_be, s_wd;

    idx       = sel64 ? 1 : 0;
    lanes     = sel64 ? 8 : 4;
    tmo       = sel64 ? 5 : 16;
    word_mask = sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    nbytes    = 1 << sz;
    ofs       = int'(addr & (lanes - 1));
    legal     = (sz != 2'd3 || sel64) && (addr % nbytes == 0);
    e_addr    = 64'(addr) - 64'(ofs);
    e_be      = ((64'd1 << nbytes) - 64'd1) << ofs;
    case (sz)
      2'd0:    e_wd = 64'(wdata[7:0])  * 64'h0101_0101_0101_0101;
      2'd1:    e_wd = 64'(wdata[15:0]) * 64'h0001_0001_0001_0001;
      2'd2:    e_wd = 64'(wdata[31:0]) * 64'h0000_0001_0000_0001;
      default: e_wd = wdata;
    endcase
    e_wd    = e_wd & word_mask;
    rd_word = rdata & word_mask;
    e_rd    = (nbytes == 8) ? rd_word
                            : (rd_word >> (8 * ofs)) & ((64'd1 << (8 * nbytes)) - 64'd1);

    if (!legal) begin
      e_err = 1'b1; e_resp_at = 1; e_req_cnt = 0;
    end else if (wait_n < tmo) begin
      e_err = 1'b0; e_resp_at = wait_n + 2; e_req_cnt = wait_n + 1;
      if (!wr) last_rd[idx] = e_rd;
    end else begin
      e_err = 1'b1; e_resp_at = tmo + 1; e_req_cnt = tmo;
      last_rd[idx] = '0;
    end

    @(negedge clk);
    check("ready_idle", 64'(o_ready), 64'd1);
    req_write = wr; req_size = sz; req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
    mem_ack   = 1'($urandom_range(0, 1));
    if (sel64) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    // Keep a scrambled request pending while busy: it must be neither taken nor used.
    mem_ack   = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_write = 1'($urandom_range(0, 1));

    n = 1; req_cnt = 0; busy_cnt = 0; resp_at = 0; stable = 1'b1;
    got_err = 1'b0; got_rd = '0;
    s_addr = '0; s_be = '0; s_wd = '0; s_we = 1'b0;
    while (resp_at == 0 && n <= 40) begin
      if (o_busy) busy_cnt++;
      if (o_rv) begin
        resp_at = n; got_err = o_err; got_rd = o_rdata;
        v32 = 1'b0; v64 = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
      end else if (o_mreq) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("mem_addr", o_maddr, e_addr);
          check("mem_be", o_be, e_be);
          check("mem_we", 64'(o_mwe), 64'(wr));
          if (wr) check("mem_wdata", o_mwd, e_wd);
          check("ready_busy", 64'(o_ready), 64'd0);
          s_addr = o_maddr; s_be = o_be; s_wd = o_mwd; s_we = o_mwe;
        end else if (o_maddr !== s_addr || o_be !== s_be || o_mwd !== s_wd || o_mwe !== s_we) begin
          stable = 1'b0;
        end
        mem_ack = (req_cnt == wait_n + 1);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    mem_ack = 1'b0; v32 = 1'b0; v64 = 1'b0;

    check("resp_latency", 64'(resp_at), 64'(e_resp_at));
    check("req_cycles", 64'(req_cnt), 64'(e_req_cnt));
    check("busy_cycles", 64'(busy_cnt), 64'(e_resp_at));
    check("resp_err", 64'(got_err), 64'(e_err));
    check("resp_rdata", got_rd, last_rd[idx]);
    check("mem_stable", 64'(stable), 64'd1);
    check("resp_pulse", 64'(o_rv), 64'd0);
    check("rdata_hold", o_rdata, last_rd[idx]);
    check("ready_after", 64'(o_ready), 64'd1);
  endtask

  // Reset pulled mid-access: outputs drop at once and no response follows.
  task automatic reset_mid_access();
    sel64 = 1'b0;
    @(negedge clk);
    v32 = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h1000; mem_ack = 1'b0;
    @(negedge clk);
    v32 = 1'b0;
    check("rst_pre_mreq", 64'(o_mreq), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mreq", 64'(o_mreq), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_rdata", o_rdata, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_resp", 64'(o_rv), 64'd0);
    end
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp_after", 64'(o_rv | rv64), 64'd0);
    end
    do_access(1'b0, 2'd2, 32'h1000, 64'd0, 64'h0000_0004, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w;
    v32 = 1'b0; v64 = 1'b0; sel64 = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_mreq", 64'(o_mreq), 64'd0);
    check("reset_rv", 64'(o_rv), 64'd0);
    check("reset_rdata", o_rdata, 64'd0);
    check("reset_be", o_be, 64'd0);
    check("reset_ready64", 64'(rdy64), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 32-bit bus
    do_access(1'b0, 2'd2, 32'h1000, 64'd0, 64'h0000_0004, 0);
    do_access(1'b1, 2'd0, 32'h1003, 64'hA5, 64'd0, 3);
    do_access(1'b0, 2'd1, 32'h1002, 64'd0, 64'hBEEF_1234, 1);
    do_access(1'b0, 2'd1, 32'h1001, 64'd0, 64'hBEEF_1234, 0);
    do_access(1'b0, 2'd2, 32'h1004, 64'd0, 64'h1234_5678, 99);
    do_access(1'b0, 2'd2, 32'h1008, 64'd0, 64'hCAFE_F00D, 15);
    do_access(1'b0, 2'd3, 32'h2008, 64'd0, 64'h1111_2222, 0);

    // 64-bit bus
    sel64 = 1'b1;
    do_access(1'b1, 2'd3, 32'h2008, 64'h1122_3344_5566_7788, 64'd0, 0);
    do_access(1'b0, 2'd3, 32'h2008, 64'd0, 64'h0123_4567_89AB_CDEF, 2);
    do_access(1'b0, 2'd2, 32'h200C, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    do_access(1'b0, 2'd3, 32'h2004, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    do_access(1'b0, 2'd0, 32'h2001, 64'd0, 64'h0123_4567_89AB_CDEF, 99);
    do_access(1'b0, 2'd1, 32'h2006, 64'd0, 64'h0123_4567_89AB_CDEF, 4);

    reset_mid_access();

    for (int k = 0; k < 300; k++) begin
      sel64 = bit'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'h3000 + 32'($urandom_range(0, 63)),
                {$urandom, $urandom}, {$urandom, $urandom}, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
